// File: rtl/rom_rafaga_pkg.sv
// rom_rafaga_pkg: shared types and helpers for the burst-read ROM.
// Burst engine states, ROM content generator and parity helper.
package rom_rafaga_pkg;

    typedef enum logic [1:0] {
        INACTIVO = 2'd0,
        LEYENDO  = 2'd1,
        VACIANDO = 2'd2
    } estado_t;

    // ROM word i is 3*i + 0x11, truncated to 'ancho' bits (ancho <= 32).
    function automatic logic [31:0] contenido(input int unsigned i, input int unsigned ancho);
        logic [31:0] v;
        v = 32'(3 * i + 32'h11);
        if (ancho < 32) begin
            v = v & ((32'h1 << ancho) - 32'h1);
        end
        return v;
    endfunction

    // Even parity: XOR of all bits, so the word plus this bit has an even number of ones.
    function automatic logic paridad(input logic [31:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/rom_nucleo.sv
// rom_nucleo: synchronous ROM with read enable; the output register holds
// its value while rd_en is low, which gives the burst engine its hold behaviour.
// Optional ROM_PARIDAD_EN adds a registered parity bit next to the data.
module rom_nucleo
    import rom_rafaga_pkg::*;
#(
    parameter int ANCHO_DATOS = 8,
    parameter int ANCHO_DIR   = 8,
    parameter int PROFUNDIDAD = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rd_en,
    input  logic [ANCHO_DIR-1:0]   dir,
`ifdef ROM_PARIDAD_EN
    output logic                   paridad_q,
`endif
    output logic [ANCHO_DATOS-1:0] datos_q
);

    logic [ANCHO_DATOS-1:0] mem [PROFUNDIDAD];
    logic [ANCHO_DATOS-1:0] datos_d;

    for (genvar i = 0; i < PROFUNDIDAD; i++) begin : g_mem
        assign mem[i] = ANCHO_DATOS'(contenido(i, ANCHO_DATOS));
    end

    // Next data word: load on read, otherwise hold.
    always_comb begin
        datos_d = datos_q;
        if (rd_en) begin
            datos_d = mem[dir];
        end
    end

    // Data output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            datos_q <= '0;
        end else begin
            datos_q <= datos_d;
        end
    end

`ifdef ROM_PARIDAD_EN
    logic paridad_d;

    // Parity follows the same load/hold rule as the data word.
    always_comb begin
        paridad_d = paridad_q;
        if (rd_en) begin
            paridad_d = paridad(32'(mem[dir]));
        end
    end

    // Parity output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            paridad_q <= 1'b0;
        end else begin
            paridad_q <= paridad_d;
        end
    end
`endif

endmodule

// File: rtl/rom_rafaga.sv
// rom_rafaga: burst-read engine over rom_nucleo. A start pulse latches a base
// address and word count; words stream out on a valid/ready handshake with
// address wrap at PROFUNDIDAD-1 and a one-cycle fin after the last beat.
// Optional macro ROM_PARIDAD_EN adds the paridad_s output.
//
// state    | meaning
// INACTIVO | idle, waiting for inicio
// LEYENDO  | words remain to be fetched
// VACIANDO | last word fetched, waiting for its handshake
module rom_rafaga
    import rom_rafaga_pkg::*;
#(
    parameter int ANCHO_DATOS = 8,
    parameter int ANCHO_DIR   = 8,
    parameter int PROFUNDIDAD = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inicio,
    input  logic [ANCHO_DIR-1:0]   dir_base,
    input  logic [ANCHO_DIR-1:0]   longitud,
    output logic                   ocupado,
    output logic [ANCHO_DATOS-1:0] datos_s,
    output logic                   valido,
    input  logic                   listo,
`ifdef ROM_PARIDAD_EN
    output logic                   paridad_s,
`endif
    output logic                   fin
);

    localparam logic [ANCHO_DIR-1:0] DIR_ULT = ANCHO_DIR'(PROFUNDIDAD - 1);

    estado_t              estado_q, estado_d;
    logic [ANCHO_DIR-1:0] dir_q, dir_d;
    logic [ANCHO_DIR-1:0] restante_q, restante_d;
    logic                 valido_q, valido_d;
    logic                 fin_q, fin_d;
    logic                 avanza;
    logic                 rd_en;

    assign avanza = !valido_q || listo;

    // Next-state, counters and read enable.
    always_comb begin
        estado_d   = estado_q;
        dir_d      = dir_q;
        restante_d = restante_q;
        valido_d   = valido_q;
        fin_d      = 1'b0;
        rd_en      = 1'b0;
        case (estado_q)
            INACTIVO: begin
                if (inicio) begin
                    // Out-of-range base addresses start from word 0.
                    dir_d      = (32'(dir_base) >= PROFUNDIDAD) ? '0 : dir_base;
                    restante_d = longitud;
                    if (longitud == '0) begin
                        fin_d = 1'b1;
                    end else begin
                        estado_d = LEYENDO;
                    end
                end
            end
            LEYENDO: begin
                if (avanza) begin
                    rd_en      = 1'b1;
                    valido_d   = 1'b1;
                    dir_d      = (dir_q == DIR_ULT) ? '0 : dir_q + 1'b1;
                    restante_d = restante_q - 1'b1;
                    if (restante_q == ANCHO_DIR'(1)) begin
                        estado_d = VACIANDO;
                    end
                end
            end
            VACIANDO: begin
                if (valido_q && listo) begin
                    valido_d = 1'b0;
                    fin_d    = 1'b1;
                    estado_d = INACTIVO;
                end
            end
            default: begin
                estado_d = INACTIVO;
                valido_d = 1'b0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q   <= INACTIVO;
            dir_q      <= '0;
            restante_q <= '0;
            valido_q   <= 1'b0;
            fin_q      <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            dir_q      <= dir_d;
            restante_q <= restante_d;
            valido_q   <= valido_d;
            fin_q      <= fin_d;
        end
    end

    rom_nucleo #(
        .ANCHO_DATOS (ANCHO_DATOS),
        .ANCHO_DIR   (ANCHO_DIR),
        .PROFUNDIDAD (PROFUNDIDAD)
    ) u_nucleo (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en     (rd_en),
        .dir       (dir_q),
`ifdef ROM_PARIDAD_EN
        .paridad_q (paridad_s),
`endif
        .datos_q   (datos_s)
    );

    assign ocupado = (estado_q != INACTIVO);
    assign valido  = valido_q;
    assign fin     = fin_q;

endmodule

// File: tb/tb_rom_rafaga.sv
// Testbench for rom_rafaga: directed bursts, expected words queued by the
// stimulus and checked by an independent monitor on each handshake.
module tb_rom_rafaga;

    logic       clk;
    logic       rst_n;
    logic       inicio;
    logic [7:0] dir_base;
    logic [7:0] longitud;
    logic       ocupado;
    logic [7:0] datos_s;
    logic       valido;
    logic       listo;
    logic       fin;
`ifdef ROM_PARIDAD_EN
    logic       paridad_s;
`endif

    int checks = 0;
    int errors = 0;
    int fin_count = 0;
    int beats = 0;
    logic [7:0] exp_q[$];
    int         len_q[$];
    logic [7:0] hold_d;
    logic       have_hold = 1'b0;

    rom_rafaga #(.ANCHO_DATOS(8), .ANCHO_DIR(8), .PROFUNDIDAD(256)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inicio   (inicio),
        .dir_base (dir_base),
        .longitud (longitud),
        .ocupado  (ocupado),
        .datos_s  (datos_s),
        .valido   (valido),
        .listo    (listo),
`ifdef ROM_PARIDAD_EN
        .paridad_s(paridad_s),
`endif
        .fin      (fin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares every accepted word, data hold under backpressure and fin bursts.
    always @(negedge clk) begin
        if (!rst_n) begin
            beats     = 0;
            have_hold = 1'b0;
        end else begin
            if (have_hold) begin
                chk("hold_valido", 32'(valido), 32'd1);
                chk("hold_datos", 32'(datos_s), 32'(hold_d));
                have_hold = 1'b0;
            end
            if (valido && listo) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL beat_extra: got 0x%0h expected no beat at %0t", datos_s, $time);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    chk("beat_datos", 32'(datos_s), 32'(e));
`ifdef ROM_PARIDAD_EN
                    chk("beat_paridad", 32'(paridad_s), 32'(^e));
`endif
                end
                beats++;
            end else if (valido && !listo) begin
                hold_d    = datos_s;
                have_hold = 1'b1;
            end
            if (fin) begin
                chk("fin_ocupado", 32'(ocupado), 32'd0);
                if (len_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL fin_extra: got fin expected none at %0t", $time);
                end else begin
                    chk("fin_beats", 32'(beats), 32'(len_q.pop_front()));
                end
                beats = 0;
                fin_count++;
            end
        end
    end

    task automatic start(input logic [7:0] b, input logic [7:0] l);
        @(posedge clk); #1;
        inicio = 1'b1; dir_base = b; longitud = l;
        @(posedge clk); #1;
        inicio = 1'b0;
        chk("ocupado_tras_inicio", 32'(ocupado), 32'(l != 8'd0));
        if (l != 8'd0) begin
            @(posedge clk); #1;
            chk("latencia_valido", 32'(valido), 32'd1);
        end
    endtask

    task automatic wait_fin(input int fc);
        int n;
        n = 0;
        while (fin_count <= fc && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        if (fin_count <= fc) begin
            checks++; errors++;
            $display("FAIL fin_timeout: got no fin expected fin within 100 cycles at %0t", $time);
        end
    endtask

    initial begin
        logic [7:0] sb_dir [5];
        logic [7:0] sb_dat [5];
        int fc;
        sb_dir = '{8'd0, 8'd3, 8'd5, 8'd8, 8'd10};
        sb_dat = '{8'h11, 8'h1A, 8'h20, 8'h29, 8'h2F};

        rst_n = 1'b0; inicio = 1'b0; dir_base = '0; longitud = '0; listo = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ocupado", 32'(ocupado), 32'd0);
        chk("rst_valido", 32'(valido), 32'd0);
        chk("rst_fin", 32'(fin), 32'd0);
        chk("rst_datos", 32'(datos_s), 32'd0);
        rst_n = 1'b1;

        // Single-word bursts.
        for (int i = 0; i < 5; i++) begin
            fc = fin_count;
            exp_q.push_back(sb_dat[i]);
            len_q.push_back(1);
            start(sb_dir[i], 8'd1);
            wait_fin(fc);
        end

        // Wrap-around from 254.
        fc = fin_count;
        exp_q.push_back(8'h0B); exp_q.push_back(8'h0E);
        exp_q.push_back(8'h11); exp_q.push_back(8'h14);
        len_q.push_back(4);
        start(8'd254, 8'd4);
        wait_fin(fc);

        // Backpressure: listo low for 3 cycles after first valid.
        fc = fin_count;
        listo = 1'b0;
        exp_q.push_back(8'h1A); exp_q.push_back(8'h1D); exp_q.push_back(8'h20);
        len_q.push_back(3);
        start(8'd3, 8'd3);
        repeat (3) @(posedge clk);
        #1 listo = 1'b1;
        wait_fin(fc);

        // Zero length: fin with no beats.
        fc = fin_count;
        len_q.push_back(0);
        start(8'd7, 8'd0);
        wait_fin(fc);
        chk("cero_valido", 32'(valido), 32'd0);

        // inicio during a burst is ignored.
        fc = fin_count;
        exp_q.push_back(8'h4D); exp_q.push_back(8'h50); exp_q.push_back(8'h53);
        exp_q.push_back(8'h56); exp_q.push_back(8'h59);
        len_q.push_back(5);
        start(8'd20, 8'd5);
        inicio = 1'b1; dir_base = 8'd0; longitud = 8'd1;
        @(posedge clk); #1 inicio = 1'b0;
        wait_fin(fc);
        repeat (3) @(posedge clk);
        #1;
        chk("ignorado_ocupado", 32'(ocupado), 32'd0);
        chk("ignorado_valido", 32'(valido), 32'd0);

        // Reset mid-burst after two beats.
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(3 * i + 8'h11));
        len_q.push_back(8);
        start(8'd0, 8'd8);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_medio_valido", 32'(valido), 32'd0);
        chk("rst_medio_ocupado", 32'(ocupado), 32'd0);
        chk("rst_medio_fin", 32'(fin), 32'd0);
        chk("rst_medio_restantes", 32'(exp_q.size()), 32'd6);
        exp_q.delete();
        len_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;

        fc = fin_count;
        exp_q.push_back(8'h2F); exp_q.push_back(8'h32);
        len_q.push_back(2);
        start(8'd10, 8'd2);
        wait_fin(fc);

        repeat (3) @(posedge clk);
        #1;
        chk("cola_datos_vacia", 32'(exp_q.size()), 32'd0);
        chk("cola_fin_vacia", 32'(len_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
